// File: rtl/gpio_cfg_pkg.sv
// Shared constants and types for the GPIO pad configuration loader.
// Holds the config word width, the common pad mode encodings and the sequencer state encoding.
package gpio_cfg_pkg;

  localparam int CFG_BITS = 13;

  localparam logic [CFG_BITS-1:0] GPIO_MODE_MGMT_STD_INPUT_NOPULL = 13'h0403;
  localparam logic [CFG_BITS-1:0] GPIO_MODE_MGMT_STD_OUTPUT       = 13'h1809;
  localparam logic [CFG_BITS-1:0] GPIO_MODE_USER_STD_INPUT_NOPULL = 13'h0402;
  localparam logic [CFG_BITS-1:0] GPIO_MODE_USER_STD_OUTPUT       = 13'h1808;

  localparam logic [CFG_BITS-1:0] CFG_DEFAULT = GPIO_MODE_MGMT_STD_INPUT_NOPULL;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_SHIFT,
    ST_LOAD,
    ST_DONE
  } xfer_state_t;

endpackage

// File: rtl/gpio_cfg_tick.sv
// Half-bit timebase: tick fires every CLKDIV enabled cycles, and phase toggles on each tick.
// A synchronous clear restarts both the count and the phase.
module gpio_cfg_tick #(
  parameter int CLKDIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick,
  output logic phase
);

  localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(CLKDIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (clr) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (tick) begin
      cnt   <= '0;
      phase <= ~phase;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/gpio_cfg_loader.sv
// Pad configuration sequencer: holds one config word per pad and shifts them into the two
// pad-control chains on request, then pulses serial_load so all pads latch together.
module gpio_cfg_loader
  import gpio_cfg_pkg::*;
#(
  parameter int AREA1PADS  = 19,
  parameter int TOTAL_PADS = 38,
  parameter int CLKDIV     = 2
) (
  input  logic                wb_clk_i,
  input  logic                wb_rstn_i,
  input  logic                cfg_we,
  input  logic [5:0]          cfg_addr,
  input  logic [CFG_BITS-1:0] cfg_wdata,
  output logic [CFG_BITS-1:0] cfg_rdata,
  output logic                cfg_wr_err,
  input  logic                xfer_start,
  output logic                xfer_busy,
  output logic                xfer_done,
  output logic                serial_clock,
  output logic                serial_load,
  output logic                serial_resetn,
  output logic                serial_data_1,
  output logic                serial_data_2
);

  localparam int N2 = TOTAL_PADS - AREA1PADS;
  localparam int NW = (AREA1PADS > N2) ? AREA1PADS : N2;
  localparam int Z2 = NW - N2;
  localparam logic [6:0] TOTAL_W = 7'(TOTAL_PADS);
  localparam logic [5:0] LAST_W  = 6'(NW - 1);
  localparam logic [3:0] LAST_B  = 4'(CFG_BITS - 1);

  xfer_state_t         state;
  logic [CFG_BITS-1:0] cfg_mem [TOTAL_PADS];
  logic [5:0]          word_idx, sel_w;
  logic [3:0]          bit_idx, sel_b, sel_bit;
  int                  p1, p2;
  logic                tick, phase, tick_en, tick_clr;
  logic                addr_ok, wr_ok, last_step, nxt_d1, nxt_d2;

  assign addr_ok   = ({1'b0, cfg_addr} < TOTAL_W);
  assign wr_ok     = cfg_we && (state == ST_IDLE) && addr_ok;
  assign cfg_rdata = addr_ok ? cfg_mem[cfg_addr] : '0;
  assign tick_en   = (state == ST_RST) || (state == ST_SHIFT) || (state == ST_LOAD);
  assign tick_clr  = (state == ST_IDLE);

  gpio_cfg_tick #(.CLKDIV(CLKDIV)) u_tick (
    .clk   (wb_clk_i),
    .rst_n (wb_rstn_i),
    .en    (tick_en),
    .clr   (tick_clr),
    .tick  (tick),
    .phase (phase)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      for (int i = 0; i < TOTAL_PADS; i++) cfg_mem[i] <= CFG_DEFAULT;
    end else if (wr_ok) begin
      cfg_mem[cfg_addr] <= cfg_wdata;
    end
  end

  // Step whose data is presented next: step 0 when leaving RST, the following step in SHIFT.
  always_comb begin
    sel_w = word_idx;
    sel_b = bit_idx;
    if (state == ST_SHIFT) begin
      if (bit_idx == LAST_B) begin
        sel_w = word_idx + 6'd1;
        sel_b = '0;
      end else begin
        sel_b = bit_idx + 4'd1;
      end
    end
  end

  assign last_step = (word_idx == LAST_W) && (bit_idx == LAST_B);
  assign sel_bit   = LAST_B - sel_b;

  // The shorter chain maps its leading word slots to pads outside its range, which send zeros.
  always_comb begin
    p1     = NW - 1 - int'(sel_w);
    p2     = AREA1PADS - Z2 + int'(sel_w);
    nxt_d1 = 1'b0;
    nxt_d2 = 1'b0;
    if (p1 >= 0 && p1 < AREA1PADS) nxt_d1 = cfg_mem[6'(p1)][sel_bit];
    if (p2 >= AREA1PADS && p2 < TOTAL_PADS) nxt_d2 = cfg_mem[6'(p2)][sel_bit];
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state         <= ST_IDLE;
      word_idx      <= '0;
      bit_idx       <= '0;
      serial_clock  <= 1'b0;
      serial_load   <= 1'b0;
      serial_resetn <= 1'b0;
      serial_data_1 <= 1'b0;
      serial_data_2 <= 1'b0;
      xfer_busy     <= 1'b0;
      xfer_done     <= 1'b0;
      cfg_wr_err    <= 1'b0;
    end else begin
      cfg_wr_err <= cfg_we && !wr_ok;
      xfer_done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          xfer_busy     <= 1'b0;
          serial_resetn <= 1'b1;
          if (xfer_start) begin
            state         <= ST_RST;
            xfer_busy     <= 1'b1;
            serial_resetn <= 1'b0;
            word_idx      <= '0;
            bit_idx       <= '0;
          end
        end
        ST_RST: begin
          if (tick && phase) begin
            state         <= ST_SHIFT;
            serial_resetn <= 1'b1;
            serial_data_1 <= nxt_d1;
            serial_data_2 <= nxt_d2;
          end
        end
        ST_SHIFT: begin
          if (tick && !phase) begin
            serial_clock <= 1'b1;
          end else if (tick) begin
            serial_clock <= 1'b0;
            if (last_step) begin
              state         <= ST_LOAD;
              serial_load   <= 1'b1;
              serial_data_1 <= 1'b0;
              serial_data_2 <= 1'b0;
            end else begin
              word_idx      <= sel_w;
              bit_idx       <= sel_b;
              serial_data_1 <= nxt_d1;
              serial_data_2 <= nxt_d2;
            end
          end
        end
        ST_LOAD: begin
          if (tick && !phase) serial_load <= 1'b0;
          else if (tick) state <= ST_DONE;
        end
        ST_DONE: begin
          xfer_done <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_cfg_loader.sv
// Scoreboard bench for gpio_cfg_loader: three instances (default, AREA1PADS=20, CLKDIV=1),
// each with a pad-chain shift-register model whose latched contents are checked at xfer_done.
module tb_gpio_cfg_loader;

  typedef struct {
    int               done_cyc;
    int               rises;
    int               rst_low;
    int               load_hi;
    logic [38*13-1:0] words;
  } exp_t;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        rstn   [3];
  logic        we     [3];
  logic [5:0]  addr   [3];
  logic [12:0] wdata  [3];
  logic        start  [3];
  logic [12:0] rdata  [3];
  logic        wr_err [3];
  logic        busy   [3];
  logic        done   [3];
  logic        sclk   [3];
  logic        sload  [3];
  logic        srstn  [3];
  logic        sd1    [3];
  logic        sd2    [3];

  logic [12:0] shadow [3][38];
  exp_t        sb_q   [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  function automatic int lat_of(input int g);
    case (g)
      1:       return 1049;
      2:       return 499;
      default: return 997;
    endcase
  endfunction

  function automatic int nb_of(input int g);
    return (g == 1) ? 260 : 247;
  endfunction

  function automatic int cd_of(input int g);
    return (g == 2) ? 1 : 2;
  endfunction

  for (genvar G = 0; G < 3; G++) begin : g_inst
    localparam int A1 = (G == 1) ? 20 : 19;
    localparam int CD = (G == 2) ? 1 : 2;

    gpio_cfg_loader #(.AREA1PADS(A1), .TOTAL_PADS(38), .CLKDIV(CD)) dut (
      .wb_clk_i      (clk),
      .wb_rstn_i     (rstn[G]),
      .cfg_we        (we[G]),
      .cfg_addr      (addr[G]),
      .cfg_wdata     (wdata[G]),
      .cfg_rdata     (rdata[G]),
      .cfg_wr_err    (wr_err[G]),
      .xfer_start    (start[G]),
      .xfer_busy     (busy[G]),
      .xfer_done     (done[G]),
      .serial_clock  (sclk[G]),
      .serial_load   (sload[G]),
      .serial_resetn (srstn[G]),
      .serial_data_1 (sd1[G]),
      .serial_data_2 (sd2[G])
    );

    logic [64*13-1:0] c1, c2;
    logic [12:0]      latched [38];
    int               rise_total = 0;
    int               rise_base = 0;
    int               rst_low = 0;
    int               load_hi = 0;
    exp_t             e;

    // Chain 1 enters at pad 0 bit 0 and moves toward pad A1-1; chain 2 enters at pad 37.
    always @(posedge sclk[G] or negedge srstn[G]) begin
      if (!srstn[G]) begin
        c1 = '0;
        c2 = '0;
      end else begin
        c1 = {c1[64*13-2:0], sd1[G]};
        c2 = {c2[64*13-2:0], sd2[G]};
        rise_total++;
      end
    end

    always @(posedge sload[G]) begin
      for (int k = 0; k < 38; k++)
        latched[k] = (k < A1) ? c1[k*13 +: 13] : c2[(37-k)*13 +: 13];
    end

    always @(negedge clk) begin
      if (!rstn[G]) begin
        rst_low   = 0;
        load_hi   = 0;
        rise_base = rise_total;
      end else begin
        if (!srstn[G]) rst_low++;
        if (sload[G]) load_hi++;
        if (done[G]) begin
          if (sb_q[G].size() == 0) begin
            check_output($sformatf("g%0d_unexpected_done", G), 1, 0);
          end else begin
            e = sb_q[G].pop_front();
            check_output($sformatf("g%0d_done_cycle", G), cyc, e.done_cyc);
            check_output($sformatf("g%0d_rises", G), rise_total - rise_base, e.rises);
            check_output($sformatf("g%0d_resetn_low", G), rst_low, e.rst_low);
            check_output($sformatf("g%0d_load_high", G), load_hi, e.load_hi);
            for (int k = 0; k < 38; k++)
              check_output($sformatf("g%0d_pad%0d", G, k), latched[k], e.words[k*13 +: 13]);
          end
          rst_low   = 0;
          load_hi   = 0;
          rise_base = rise_total;
        end
      end
    end
  end

  task automatic apply_stimulus(input int g, input bit we_i, input bit [5:0] a,
                                input bit [12:0] d, input bit st, input bit exp_err,
                                input bit exp_start);
    exp_t x;
    @(negedge clk);
    we[g]    = we_i;
    addr[g]  = a;
    wdata[g] = d;
    start[g] = st;
    @(posedge clk);
    #1;
    we[g]    = 1'b0;
    start[g] = 1'b0;
    if (we_i) begin
      check_output($sformatf("g%0d_wr_err_a%0d", g, a), wr_err[g], exp_err);
      if (!exp_err) shadow[g][a] = d;
    end
    if (exp_start) begin
      check_output($sformatf("g%0d_busy_after_start", g), busy[g], 1);
      x.done_cyc = cyc + lat_of(g);
      x.rises    = nb_of(g);
      x.rst_low  = 2 * cd_of(g);
      x.load_hi  = cd_of(g);
      for (int k = 0; k < 38; k++) x.words[k*13 +: 13] = shadow[g][k];
      sb_q[g].push_back(x);
    end
  endtask

  task automatic read_word(input int g, input bit [5:0] a);
    @(negedge clk);
    addr[g] = a;
    #1;
    check_output($sformatf("g%0d_rdata_a%0d", g, a), rdata[g], (a < 38) ? shadow[g][a] : 0);
  endtask

  task automatic check_idle(input int g, input bit exp_srstn);
    check_output($sformatf("g%0d_serial_clock", g), sclk[g], 0);
    check_output($sformatf("g%0d_serial_load", g), sload[g], 0);
    check_output($sformatf("g%0d_serial_resetn", g), srstn[g], exp_srstn);
    check_output($sformatf("g%0d_serial_data_1", g), sd1[g], 0);
    check_output($sformatf("g%0d_serial_data_2", g), sd2[g], 0);
    check_output($sformatf("g%0d_xfer_busy", g), busy[g], 0);
    check_output($sformatf("g%0d_xfer_done", g), done[g], 0);
    check_output($sformatf("g%0d_cfg_wr_err", g), wr_err[g], 0);
  endtask

  task automatic wait_idle(input int g, input int budget);
    int n = 0;
    while (busy[g] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output($sformatf("g%0d_idle_in_time", g), busy[g], 0);
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      rstn[g]  = 1'b0;
      we[g]    = 1'b0;
      addr[g]  = '0;
      wdata[g] = '0;
      start[g] = 1'b0;
      for (int k = 0; k < 38; k++) shadow[g][k] = 13'h0403;
    end
    repeat (3) @(negedge clk);
    #2;
    for (int g = 0; g < 3; g++) rstn[g] = 1'b1;
    @(negedge clk);

    $display("[TB] reset state and default words");
    for (int g = 0; g < 3; g++) check_idle(g, 1'b1);
    for (int k = 0; k < 38; k++) read_word(0, 6'(k));
    read_word(1, 6'd37);
    read_word(2, 6'd0);

    $display("[TB] extreme words on both chain ends");
    apply_stimulus(0, 1'b1, 6'd0, 13'h1FFF, 1'b0, 1'b0, 1'b0);
    apply_stimulus(0, 1'b1, 6'd37, 13'h0001, 1'b0, 1'b0, 1'b0);
    apply_stimulus(0, 1'b0, 6'd0, 13'h0000, 1'b1, 1'b0, 1'b1);
    wait_idle(0, 2000);

    $display("[TB] unequal chains, AREA1PADS=20");
    apply_stimulus(1, 1'b1, 6'd0, 13'h1234, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1, 1'b1, 6'd19, 13'h1ABC, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1, 1'b1, 6'd20, 13'h0F0F, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1, 1'b1, 6'd37, 13'h1555, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1, 1'b0, 6'd0, 13'h0000, 1'b1, 1'b0, 1'b1);
    wait_idle(1, 2000);

    $display("[TB] dropped writes and ignored start while busy");
    apply_stimulus(0, 1'b0, 6'd0, 13'h0000, 1'b1, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    apply_stimulus(0, 1'b1, 6'd3, 13'h0777, 1'b0, 1'b1, 1'b0);
    apply_stimulus(0, 1'b0, 6'd0, 13'h0000, 1'b1, 1'b0, 1'b0);
    wait_idle(0, 2000);
    apply_stimulus(0, 1'b1, 6'd40, 13'h0555, 1'b0, 1'b1, 1'b0);
    read_word(0, 6'd3);
    read_word(0, 6'd40);
    read_word(0, 6'd0);

    $display("[TB] reset in the middle of a transfer");
    apply_stimulus(0, 1'b1, 6'd7, 13'h0123, 1'b1, 1'b0, 1'b1);
    repeat (404) @(negedge clk);
    #2;
    rstn[0] = 1'b0;
    #1;
    check_idle(0, 1'b0);
    sb_q[0].delete();
    for (int k = 0; k < 38; k++) shadow[0][k] = 13'h0403;
    repeat (2) @(negedge clk);
    read_word(0, 6'd7);
    #2;
    rstn[0] = 1'b1;
    @(negedge clk);
    check_idle(0, 1'b1);
    apply_stimulus(0, 1'b1, 6'd5, 13'h0A5A, 1'b0, 1'b0, 1'b0);
    apply_stimulus(0, 1'b0, 6'd0, 13'h0000, 1'b1, 1'b0, 1'b1);
    wait_idle(0, 2000);

    $display("[TB] write and start together, CLKDIV=1");
    apply_stimulus(2, 1'b1, 6'd18, 13'h1C3A, 1'b1, 1'b0, 1'b1);
    wait_idle(2, 2000);

    repeat (4) @(negedge clk);
    for (int g = 0; g < 3; g++)
      check_output($sformatf("g%0d_pending", g), sb_q[g].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
